// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register: valid/ready handshake, 2-entry skid, flush-to-bubble, field decode.
// Define IFID_PERF_CNT_EN to add saturating stall_cnt / flush_cnt outputs.
module ifid_skid_reg #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INS_W   = 32,
    parameter logic [31:0] NOP_INS = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pcp4,
    input  logic [INS_W-1:0] in_ins,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pcp4,
    output logic [INS_W-1:0] out_ins,
    output logic [5:0]       op,
    output logic [4:0]       rs_fmt,
    output logic [4:0]       rt_ft,
    output logic [4:0]       rd_fs,
    output logic [4:0]       sh_fd,
    output logic [5:0]       fun,
    output logic [15:0]      im,
    output logic [25:0]      ad
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
`endif
);

    localparam logic [INS_W-1:0] NopIns = INS_W'(NOP_INS);

    logic             main_valid_q, main_valid_d;
    logic [PC_W-1:0]  main_pcp4_q, main_pcp4_d;
    logic [INS_W-1:0] main_ins_q, main_ins_d;
    logic             skid_valid_q, skid_valid_d;
    logic [PC_W-1:0]  skid_pcp4_q, skid_pcp4_d;
    logic [INS_W-1:0] skid_ins_q, skid_ins_d;

    logic accept;
    logic deliver;

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign deliver  = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_pcp4_d  = main_pcp4_q;
        main_ins_d   = main_ins_q;
        skid_valid_d = skid_valid_q;
        skid_pcp4_d  = skid_pcp4_q;
        skid_ins_d   = skid_ins_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || deliver) begin
            // Skid holds the older word, so it always wins the refill of main.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_pcp4_d  = skid_pcp4_q;
                main_ins_d   = skid_ins_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_pcp4_d  = in_pcp4;
                main_ins_d   = in_ins;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_pcp4_d  = in_pcp4;
            skid_ins_d   = in_ins;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_pcp4_q  <= '0;
            main_ins_q   <= NopIns;
            skid_valid_q <= 1'b0;
            skid_pcp4_q  <= '0;
            skid_ins_q   <= NopIns;
        end else begin
            main_valid_q <= main_valid_d;
            main_pcp4_q  <= main_pcp4_d;
            main_ins_q   <= main_ins_d;
            skid_valid_q <= skid_valid_d;
            skid_pcp4_q  <= skid_pcp4_d;
            skid_ins_q   <= skid_ins_d;
        end
    end

    always_comb begin
        out_valid = main_valid_q;
        out_pcp4  = main_valid_q ? main_pcp4_q : '0;
        out_ins   = main_valid_q ? main_ins_q : NopIns;
    end

    assign op     = out_ins[31:26];
    assign rs_fmt = out_ins[25:21];
    assign rt_ft  = out_ins[20:16];
    assign rd_fs  = out_ins[15:11];
    assign sh_fd  = out_ins[10:6];
    assign fun    = out_ins[5:0];
    assign im     = out_ins[15:0];
    assign ad     = out_ins[25:0];

`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [1:0]  flush_kill;
    logic [32:0] flush_sum;

    // A word delivered in the flush cycle was consumed by decode, not killed.
    assign flush_kill = {1'b0, main_valid_q & ~deliver} + {1'b0, skid_valid_q};
    assign flush_sum  = {1'b0, flush_cnt_q} + {31'b0, flush_kill};

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (main_valid_q && !out_ready && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush) begin
            flush_cnt_d = flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Scoreboard bench for ifid_skid_reg: a 2-deep FIFO model drives expectations, a negedge
// monitor compares every presented word and the handshake flags.
module tb_ifid_skid_reg;

    localparam logic [31:0] Nop = 32'h0000_0040;

    typedef struct packed {
        logic [31:0] pcp4;
        logic [31:0] ins;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pcp4 = '0;
    logic [31:0] in_ins = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pcp4;
    logic [31:0] out_ins;
    logic [5:0]  op;
    logic [4:0]  rs_fmt, rt_ft, rd_fs, sh_fd;
    logic [5:0]  fun;
    logic [15:0] im;
    logic [25:0] ad;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
    logic [31:0] stall_exp = '0;
    logic [31:0] flush_exp = '0;
`endif

    ifid_skid_reg #(.PC_W(32), .INS_W(32), .NOP_INS(Nop)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pcp4(in_pcp4), .in_ins(in_ins),
        .out_valid(out_valid), .out_ready(out_ready), .out_pcp4(out_pcp4), .out_ins(out_ins),
        .op(op), .rs_fmt(rs_fmt), .rt_ft(rt_ft), .rd_fs(rd_fs), .sh_fd(sh_fd),
        .fun(fun), .im(im), .ad(ad)
`ifdef IFID_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    word_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;
    logic  mon_en = 1'b0;
    logic  cur_acc = 1'b0;
    logic  cur_flush = 1'b0;
    logic  cur_stall = 1'b0;
    word_t cur_word;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares handshake flags and the presented word against the model head.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            automatic int occ = sb.size();
            chk("out_valid", 64'(out_valid), 64'(occ > 0));
            chk("in_ready", 64'(in_ready), 64'(occ < 2));
`ifdef IFID_PERF_CNT_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
            chk("flush_cnt", 64'(flush_cnt), 64'(flush_exp));
`endif
            if (occ > 0) begin
                automatic word_t e = sb[0];
                chk("out_pcp4", 64'(out_pcp4), 64'(e.pcp4));
                chk("out_ins", 64'(out_ins), 64'(e.ins));
                chk("op", 64'(op), 64'(e.ins >> 26));
                chk("rs_fmt", 64'(rs_fmt), 64'((e.ins >> 21) % 32));
                chk("rt_ft", 64'(rt_ft), 64'((e.ins >> 16) % 32));
                chk("rd_fs", 64'(rd_fs), 64'((e.ins >> 11) % 32));
                chk("sh_fd", 64'(sh_fd), 64'((e.ins >> 6) % 32));
                chk("fun", 64'(fun), 64'(e.ins % 64));
                chk("im", 64'(im), 64'(e.ins % 65536));
                chk("ad", 64'(ad), 64'(e.ins % (1 << 26)));
                if (out_ready) void'(sb.pop_front());
            end else begin
                chk("bubble_pcp4", 64'(out_pcp4), 64'(0));
                chk("bubble_ins", 64'(out_ins), 64'(Nop));
            end
        end
    end

    // One clock: commit the previous cycle's inputs to the model, then drive new ones.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl);
        @(posedge clk);
`ifdef IFID_PERF_CNT_EN
        if (cur_stall && stall_exp != 32'hFFFF_FFFF) stall_exp = stall_exp + 1;
        if (cur_flush) begin
            automatic longint s = longint'(flush_exp) + sb.size();
            flush_exp = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
        end
`endif
        if (cur_flush) sb.delete();
        else if (cur_acc) sb.push_back(cur_word);
        #1;
        in_valid  = v;
        in_pcp4   = pc;
        in_ins    = ins;
        out_ready = ordy;
        flush     = fl;
        cur_word  = '{pcp4: pc, ins: ins};
        cur_acc   = v && (sb.size() < 2);
        cur_flush = fl;
        cur_stall = (sb.size() > 0) && !ordy;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 32'h0, ordy, 1'b0);
    endtask

    initial begin
        cur_word = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_pcp4", 64'(out_pcp4), 64'(0));
        chk("rst_out_ins", 64'(out_ins), 64'(Nop));
        chk("rst_fun", 64'(fun), 64'(Nop % 64));
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Streaming: two words back-to-back with decode ready.
        step(1'b1, 32'h4, 32'h8C22_0004, 1'b1, 1'b0);
        step(1'b1, 32'h8, 32'h0043_0820, 1'b1, 1'b0);
        chk("lw_op", 64'(op), 64'(6'h23));
        chk("lw_rs", 64'(rs_fmt), 64'(1));
        chk("lw_rt", 64'(rt_ft), 64'(2));
        chk("lw_im", 64'(im), 64'(16'h0004));
        idle(1'b1);
        chk("second_valid", 64'(out_valid), 64'(1));
        chk("second_pcp4", 64'(out_pcp4), 64'(32'h8));
        idle(1'b1);

        // Backpressure: A in main, B in skid, C refused.
        step(1'b1, 32'h10, 32'hA000_0001, 1'b0, 1'b0);
        step(1'b1, 32'h14, 32'hB000_0002, 1'b0, 1'b0);
        step(1'b1, 32'h18, 32'hC000_0003, 1'b0, 1'b0);
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        step(1'b1, 32'h18, 32'hC000_0003, 1'b1, 1'b0);
        repeat (4) idle(1'b1);

        // Flush with full skid and a simultaneous offer.
        step(1'b1, 32'h20, 32'hA100_0001, 1'b0, 1'b0);
        step(1'b1, 32'h24, 32'hB100_0002, 1'b0, 1'b0);
        step(1'b1, 32'h28, 32'hC100_0003, 1'b0, 1'b1);
        idle(1'b0);
        chk("fl_out_valid", 64'(out_valid), 64'(0));
        chk("fl_out_ins", 64'(out_ins), 64'(Nop));
        chk("fl_in_ready", 64'(in_ready), 64'(1));
`ifdef IFID_PERF_CNT_EN
        chk("fl_cnt_two", 64'(flush_cnt), 64'(2));
`endif

        // Flush vs accept on an empty block.
        step(1'b1, 32'h30, 32'hD000_0004, 1'b1, 1'b1);
        idle(1'b1);
        chk("fl_empty_valid", 64'(out_valid), 64'(0));

        // Stall with held word for 5 cycles, then drain.
        step(1'b1, 32'h34, 32'hE000_0005, 1'b0, 1'b0);
        repeat (5) idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // Async reset between edges with skid full.
        step(1'b1, 32'h40, 32'hA200_0001, 1'b0, 1'b0);
        step(1'b1, 32'h44, 32'hB200_0002, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        sb.delete();
        sb.push_back('{pcp4: 32'h40, ins: 32'hA200_0001});
        sb.push_back('{pcp4: 32'h44, ins: 32'hB200_0002});
        #3 rst_n = 1'b0;
        sb.delete();
        cur_acc = 1'b0;
        cur_flush = 1'b0;
        cur_stall = 1'b0;
`ifdef IFID_PERF_CNT_EN
        stall_exp = '0;
        flush_exp = '0;
`endif
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        chk("arst_out_pcp4", 64'(out_pcp4), 64'(0));
        chk("arst_out_ins", 64'(out_ins), 64'(Nop));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end
        repeat (4) idle(1'b1);
        chk("drain_empty", 64'(sb.size()), 64'(0));

        @(posedge clk);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifid_skid_reg.md
Name: ifid_skid_reg

Overview:
- Parametrised IF/ID pipeline register with a valid/ready handshake, 2-entry skid storage, synchronous flush and instruction-field decode.
- Sits between the fetch stage (PC+4, instruction word) and the decode stage.
- Successor to the fixed free-running IF/ID latch: adds backpressure (stall), flush-to-bubble and reset, and is width-generic.

Parameters:
- PC_W, 32, width of the PC+4 payload.
- INS_W, 32, instruction width; must be ≥32, field slices taken from bits [31:0].
- NOP_INS, 32'h0000_0000, instruction word presented on out_ins while out_valid=0; zero-extended to INS_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- flush  in  1  synchronous kill of all held entries (branch taken / exception).
- in_valid  in  1  fetch presents a word.
- in_ready  out  1  block can accept.
- in_pcp4  in  PC_W  PC+4 from fetch.
- in_ins  in  INS_W  fetched instruction.
- out_valid  out  1  decode-side word valid.
- out_ready  in  1  decode accepts.
- out_pcp4  out  PC_W  held PC+4.
- out_ins  out  INS_W  held instruction.
- op  out  6  out_ins[31:26].
- rs_fmt  out  5  out_ins[25:21].
- rt_ft  out  5  out_ins[20:16].
- rd_fs  out  5  out_ins[15:11].
- sh_fd  out  5  out_ins[10:6].
- fun  out  6  out_ins[5:0].
- im  out  16  out_ins[15:0].
- ad  out  26  out_ins[25:0].

Behaviour:
- Storage: main entry (drives outputs) plus skid entry; each has a valid bit and pcp4/ins payload.
- Reset (rst_n=0, async):
  - main_valid=skid_valid=0.
  - Payloads: pcp4=0, ins=NOP_INS.
  - Outputs: out_valid=0, in_ready=1, out_pcp4=0, out_ins=NOP_INS; fields decode NOP_INS.
- in_ready = !skid_valid. It is a registered state decode, with no combinational path from out_ready.
- Accept = in_valid & in_ready; deliver = out_valid & out_ready.
- Latency: word accepted in cycle N appears on outputs in cycle N+1. Throughput is 1 word/cycle while out_ready=1.
- Per-edge update, no flush:
  - main empty or delivered this cycle:
    - skid valid → main←skid, skid cleared.
    - else if accept → main←input.
    - else main_valid←0.
  - main full and not delivered:
    - accept → skid←input.
    - main holds.
- The skid never overflows: with skid full, in_ready=0.
- Ordering is strictly FIFO. No word is duplicated or lost except by flush.
- Payload of an invalid entry is don't-care internally. Outputs are forced: when out_valid=0, out_pcp4=0 and out_ins=NOP_INS.
- flush=1 at an edge:
  - main_valid←0, skid_valid←0.
  - Any simultaneous accept is discarded; flush dominates accept and deliver.
  - A deliver in the flush cycle is still counted as consumed by decode.
  - Next cycle: out_valid=0, in_ready=1.
- Reset mid-operation: held entries are lost immediately and asynchronously. There is no output glitch beyond the async transition to reset values.
- Fields are pure slices of out_ins. There is no sign extension; that is done in decode.

Optional Feature:
- Macro IFID_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt [31:0] and flush_cnt [31:0], both reset to 0.
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments by the number of valid entries killed by a flush (0, 1 or 2).
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then stream: out_ready=1, push ins 0x8C220004 pcp4 0x4, then 0x00430820 pcp4 0x8 → appear 1 cycle later in order; first shows op=0x23, rs_fmt=1, rt_ft=2, im=0x0004; out_valid stays high 2 cycles.
- Backpressure: out_ready=0, push A,B,C back-to-back → A on outputs, B in skid, in_ready=0 and C not accepted; raise out_ready → A,B,C delivered in order with no loss or duplicate.
- Flush with full skid: main=A, skid=B, flush=1 with in_valid=1 (C) → next cycle out_valid=0, out_ins=NOP_INS, in_ready=1, C dropped; with macro, flush_cnt=2.
- Flush vs accept on empty block: flush=1, in_valid=1 → out_valid remains 0.
- Async reset mid-stall: assert rst_n=0 between edges with skid full → out_valid=0, in_ready=1 immediately; out_pcp4=0.
- Macro build, stall count: hold out_ready=0 for 5 cycles with out_valid=1 → stall_cnt=5; preload near max → saturates at 0xFFFFFFFF.
